// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill count, threshold flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_MARGIN  = 4,
  parameter int AE_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] FULL_LVL = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LVL   = CW'(AE_MARGIN);
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

  if (AF_MARGIN < 0 || AF_MARGIN > DEPTH - 1 ||
      AE_MARGIN < 0 || AE_MARGIN > DEPTH - 1) begin : g_bad_margin
    $error("sync_fifo_ctrl: AF_MARGIN/AE_MARGIN outside 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses registered flags only: no same-cycle bypass at full/empty.
  always_comb begin
    wr_acc  = wr_req & ~fifo_full;
    rd_acc  = rd_req & ~fifo_empty;
    cnt_nxt = fill_count;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = fill_count + ONE;
      2'b01:   cnt_nxt = fill_count - ONE;
      default: cnt_nxt = fill_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      fill_count   <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ONE;
      if (rd_acc) rptr <= rptr + ONE;
      fill_count   <= cnt_nxt;
      fifo_full    <= (cnt_nxt == FULL_LVL);
      fifo_empty   <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_LVL);
      almost_empty <= (cnt_nxt <= AE_LVL);
      wr_err       <= wr_req & fifo_full;
      rd_err       <= rd_req & fifo_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = fifo_empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem[rptr[ADDR_WIDTH-1:0]];
    end
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model, random data.
// Covers default 512-deep build plus a 4-deep instance.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 512;
  localparam int CW    = 10;
  localparam int AFM   = 4;
  localparam int AEM   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        fifo_full, fifo_empty, almost_full, almost_empty;
  logic [9:0]  fill_count;
  logic        wr_err, rd_err;

  logic        wr_s = 1'b0;
  logic        rd_s = 1'b0;
  logic [7:0]  din_s = '0;
  logic [7:0]  dout_s;
  logic        full_s, empty_s, af_s, ae_s;
  logic [2:0]  cnt_s;
  logic        werr_s, rerr_s;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  logic [31:0] exp_dout = '0;
  logic [31:0] last_pop = '0;
  bit          exp_werr, exp_rerr;

  sync_fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .data_in(data_in),
    .rd_req(rd_req), .data_out(data_out), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fill_count(fill_count),
    .wr_err(wr_err), .rd_err(rd_err)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_MARGIN(1), .AE_MARGIN(0)
  ) dut_s (
    .clk(clk), .rst(rst), .wr_req(wr_s), .data_in(din_s),
    .rd_req(rd_s), .data_out(dout_s), .fifo_full(full_s),
    .fifo_empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .fill_count(cnt_s),
    .wr_err(werr_s), .rd_err(rerr_s)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the queue model advances alongside.
  task automatic step(input bit w, input logic [31:0] d, input bit r);
    bit aw, ar;
    wr_req  = w;
    data_in = d;
    rd_req  = r;
    aw = w && (q.size() < DEPTH);
    ar = r && (q.size() > 0);
    if (ar) begin
      last_pop = q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
      exp_dout = last_pop;
`endif
    end
    if (aw) q.push_back(d);
    exp_werr = w && !aw;
    exp_rerr = r && !ar;
    @(posedge clk);
    #1;
`ifdef SYNC_FIFO_FWFT_EN
    exp_dout = (q.size() > 0) ? q[0] : 32'd0;
`endif
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    data_in = $urandom;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    q.delete();
    exp_dout = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total += 8;
    if (fill_count !== 10'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", fill_count);
    end
    if (fifo_empty !== 1'b1) begin
      bad++; $display("FAIL reset_empty got=%b want=1", fifo_empty);
    end
    if (almost_empty !== 1'b1) begin
      bad++; $display("FAIL reset_ae got=%b want=1", almost_empty);
    end
    if (fifo_full !== 1'b0) begin
      bad++; $display("FAIL reset_full got=%b want=0", fifo_full);
    end
    if (almost_full !== 1'b0) begin
      bad++; $display("FAIL reset_af got=%b want=0", almost_full);
    end
    if (wr_err !== 1'b0) begin
      bad++; $display("FAIL reset_wr_err got=%b want=0", wr_err);
    end
    if (rd_err !== 1'b0) begin
      bad++; $display("FAIL reset_rd_err got=%b want=0", rd_err);
    end
    if (data_out !== 32'd0) begin
      bad++; $display("FAIL reset_dout got=%h want=0", data_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 32'(i), 1'b0);
      total += 3;
      if (fill_count !== CW'(i)) begin
        bad++; $display("FAIL fill_count got=%0d want=%0d", fill_count, i);
      end
      if (almost_full !== (i >= DEPTH - AFM)) begin
        bad++; $display("FAIL fill_af n=%0d got=%b", i, almost_full);
      end
      if (fifo_empty !== 1'b0) begin
        bad++; $display("FAIL fill_empty n=%0d got=%b", i, fifo_empty);
      end
    end
    total += 2;
    if (fifo_full !== 1'b1) begin
      bad++; $display("FAIL fill_full got=%b want=1", fifo_full);
    end
    if (fill_count !== 10'd512) begin
      bad++; $display("FAIL fill_final got=%0d want=512", fill_count);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] held;
    held = data_out;
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    total += 4;
    if (wr_err !== 1'b1) begin
      bad++; $display("FAIL ovf_wr_err got=%b want=1", wr_err);
    end
    if (fill_count !== 10'd512) begin
      bad++; $display("FAIL ovf_count got=%0d want=512", fill_count);
    end
    if (fifo_full !== 1'b1) begin
      bad++; $display("FAIL ovf_full got=%b want=1", fifo_full);
    end
    if (data_out !== held) begin
      bad++; $display("FAIL ovf_dout got=%h want=%h", data_out, held);
    end
    step(1'b0, '0, 1'b0);
    total++;
    if (wr_err !== 1'b0) begin
      bad++; $display("FAIL ovf_pulse got=%b want=0", wr_err);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      total += 3;
      if (last_pop !== 32'(i)) begin
        bad++; $display("FAIL drain_order got=%h want=%h", last_pop, i);
      end
      if (data_out !== exp_dout) begin
        bad++; $display("FAIL drain_dout got=%h want=%h", data_out, exp_dout);
      end
      if (fill_count !== CW'(DEPTH - i)) begin
        bad++; $display("FAIL drain_count got=%0d want=%0d", fill_count, DEPTH - i);
      end
    end
    total++;
    if (fifo_empty !== 1'b1) begin
      bad++; $display("FAIL drain_empty got=%b want=1", fifo_empty);
    end
    step(1'b0, '0, 1'b1);
    total += 3;
    if (rd_err !== 1'b1) begin
      bad++; $display("FAIL udf_rd_err got=%b want=1", rd_err);
    end
    if (data_out !== exp_dout) begin
      bad++; $display("FAIL udf_dout got=%h want=%h", data_out, exp_dout);
    end
    if (fill_count !== 10'd0) begin
      bad++; $display("FAIL udf_count got=%0d want=0", fill_count);
    end
    step(1'b0, '0, 1'b0);
    total++;
    if (rd_err !== 1'b0) begin
      bad++; $display("FAIL udf_pulse got=%b want=0", rd_err);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, $urandom, 1'b1);
      total += 4;
      if (fill_count !== 10'd3) begin
        bad++; $display("FAIL b2b_count c=%0d got=%0d want=3", i, fill_count);
      end
      if (almost_empty !== 1'b1) begin
        bad++; $display("FAIL b2b_ae c=%0d got=%b want=1", i, almost_empty);
      end
      if (data_out !== exp_dout) begin
        bad++; $display("FAIL b2b_dout c=%0d got=%h want=%h", i, data_out, exp_dout);
      end
      if ((wr_err | rd_err) !== 1'b0) begin
        bad++; $display("FAIL b2b_err c=%0d got=%b%b want=00", i, wr_err, rd_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
    do_reset();
    total += 4;
    if (fill_count !== 10'd0) begin
      bad++; $display("FAIL rmid_count got=%0d want=0", fill_count);
    end
    if (fifo_empty !== 1'b1) begin
      bad++; $display("FAIL rmid_empty got=%b want=1", fifo_empty);
    end
    if (data_out !== 32'd0) begin
      bad++; $display("FAIL rmid_dout got=%h want=0", data_out);
    end
    if ((wr_err | rd_err) !== 1'b0) begin
      bad++; $display("FAIL rmid_err got=%b%b want=00", wr_err, rd_err);
    end
    w = $urandom;
    step(1'b1, w, 1'b0);
    total += 2;
    if (fill_count !== 10'd1) begin
      bad++; $display("FAIL rmid_wr got=%0d want=1", fill_count);
    end
    if (data_out !== exp_dout) begin
      bad++; $display("FAIL rmid_fwd got=%h want=%h", data_out, exp_dout);
    end
    step(1'b0, '0, 1'b1);
    total += 2;
    if (last_pop !== w || data_out !== exp_dout) begin
      bad++; $display("FAIL rmid_rd got=%h want=%h", data_out, exp_dout);
    end
    if (fifo_empty !== 1'b1) begin
      bad++; $display("FAIL rmid_empty2 got=%b want=1", fifo_empty);
    end
  endtask

  task automatic test_random();
    bit w, r;
    int sz;
    for (int i = 0; i < 3000; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      if (i >= 1500) begin
        w = ($urandom_range(0, 99) < 40);
        r = ($urandom_range(0, 99) < 60);
      end
      step(w, $urandom, r);
      sz = q.size();
      total += 8;
      if (fill_count !== CW'(sz)) begin
        bad++; $display("FAIL rnd_count got=%0d want=%0d", fill_count, sz);
      end
      if (fifo_full !== (sz == DEPTH)) begin
        bad++; $display("FAIL rnd_full got=%b n=%0d", fifo_full, sz);
      end
      if (fifo_empty !== (sz == 0)) begin
        bad++; $display("FAIL rnd_empty got=%b n=%0d", fifo_empty, sz);
      end
      if (almost_full !== (sz >= DEPTH - AFM)) begin
        bad++; $display("FAIL rnd_af got=%b n=%0d", almost_full, sz);
      end
      if (almost_empty !== (sz <= AEM)) begin
        bad++; $display("FAIL rnd_ae got=%b n=%0d", almost_empty, sz);
      end
      if (wr_err !== exp_werr) begin
        bad++; $display("FAIL rnd_wr_err got=%b want=%b", wr_err, exp_werr);
      end
      if (rd_err !== exp_rerr) begin
        bad++; $display("FAIL rnd_rd_err got=%b want=%b", rd_err, exp_rerr);
      end
      if (data_out !== exp_dout) begin
        bad++; $display("FAIL rnd_dout got=%h want=%h", data_out, exp_dout);
      end
    end
  endtask

  task automatic test_small();
    logic [7:0] ed;
    for (int k = 1; k <= 5; k++) begin
      wr_s  = 1'b1;
      din_s = 8'(k);
      @(posedge clk);
      #1;
      wr_s = 1'b0;
      total += 4;
      if (cnt_s !== 3'((k > 4) ? 4 : k)) begin
        bad++; $display("FAIL small_cnt k=%0d got=%0d", k, cnt_s);
      end
      if (af_s !== (k >= 3)) begin
        bad++; $display("FAIL small_af k=%0d got=%b", k, af_s);
      end
      if (full_s !== (k >= 4)) begin
        bad++; $display("FAIL small_full k=%0d got=%b", k, full_s);
      end
      if (werr_s !== (k == 5)) begin
        bad++; $display("FAIL small_werr k=%0d got=%b", k, werr_s);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      rd_s = 1'b1;
      @(posedge clk);
      #1;
      rd_s = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
      ed = (i < 4) ? 8'(i + 1) : 8'd0;
`else
      ed = 8'(i);
`endif
      total += 3;
      if (cnt_s !== 3'(4 - i)) begin
        bad++; $display("FAIL small_rcnt i=%0d got=%0d", i, cnt_s);
      end
      if (ae_s !== (i == 4)) begin
        bad++; $display("FAIL small_ae i=%0d got=%b", i, ae_s);
      end
      if (dout_s !== ed) begin
        bad++; $display("FAIL small_dout i=%0d got=%h want=%h", i, dout_s, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
